// File: rtl/ttl_pkg.sv
// ttl_pkg: direction constants and terminal-state helper shared by the ttl counter family
package ttl_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic int unsigned term_value(input logic up, input int unsigned modulus);
    return (up == DIR_UP) ? modulus - 1 : 32'd0;
  endfunction
endpackage

// File: rtl/ttl_counter_term.sv
// ttl_counter_term: combinational terminal-count detect (q, up, ent -> tco; rco_n strobe when TTL_COUNTER_RCO_EN)
module ttl_counter_term
  import ttl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             ent,
`ifdef TTL_COUNTER_RCO_EN
  input  logic             enp,
  input  logic             ce,
`endif
  output logic             tco,
  output logic             rco_n
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(term_value(DIR_UP, MODULUS));
  localparam logic [WIDTH-1:0] BOT = WIDTH'(term_value(DIR_DOWN, MODULUS));
  assign tco = ent & (q == (up ? TOP : BOT));
`ifdef TTL_COUNTER_RCO_EN
  assign rco_n = ~(tco & enp & ce);
`else
  assign rco_n = 1'b1;
`endif
endmodule

// File: rtl/ttl_counter_mod.sv
// ttl_counter_mod: parametrised '16x/'19x-style presettable up/down counter, cascadable via ent/tco (rco_n strobe when TTL_COUNTER_RCO_EN)
// ports: clk, reset_n (async low), ce (emulated TTL edge), clr_n, load_n, enp, ent, up, p -> q, tco, rco_n
module ttl_counter_mod
  import ttl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 16,
  parameter int CLR_SYNC = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             clr_n,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] q,
  output logic             tco,
  output logic             rco_n
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(term_value(DIR_UP, MODULUS));
  logic [WIDTH-1:0] q_step, q_nxt;
  logic arst_n;
  // '161 style: clr_n joins the asynchronous clear path
  assign arst_n = (CLR_SYNC != 0) ? reset_n : (reset_n & clr_n);
  always_comb begin
    q_step = (up == DIR_UP) ? ((q == TOP) ? '0 : q + 1'b1) : ((q == '0) ? TOP : q - 1'b1);
    q_nxt = !ce ? q : !clr_n ? '0 : !load_n ? p : (enp & ent) ? q_step : q;
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) q <= '0;
    else q <= q_nxt;
  ttl_counter_term #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_term (
    .q(q),
    .up(up),
    .ent(ent),
`ifdef TTL_COUNTER_RCO_EN
    .enp(enp),
    .ce(ce),
`endif
    .tco(tco),
    .rco_n(rco_n)
  );
endmodule

// File: tb/tb_ttl_counter_mod.sv
// tb_ttl_counter_mod: directed table plus hand sequences for ttl_counter_mod
module tb_ttl_counter_mod;
  logic clk = 0, reset_n = 0;
  logic ce_d = 0, ce_c = 0, ce_a = 0, clr_a = 1;
  logic clr_n = 1, load_n = 1, enp = 1, ent = 1, up = 0;
  logic [3:0] p = 0;
  logic [3:0] q_d, q0, q1, q_a;
  logic tco_d, tco0, tco1, tco_a, rco_d, rco0, rco1, rco_a;
  int n_cmp = 0, n_err = 0;
  logic rco_exp;
  always #5 clk = ~clk;
  ttl_counter_mod #(.WIDTH(4), .MODULUS(10), .CLR_SYNC(1)) ud (
    .clk(clk), .reset_n(reset_n), .ce(ce_d), .clr_n(clr_n), .load_n(load_n), .enp(enp),
    .ent(ent), .up(up), .p(p), .q(q_d), .tco(tco_d), .rco_n(rco_d));
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .CLR_SYNC(1)) u0 (
    .clk(clk), .reset_n(reset_n), .ce(ce_c), .clr_n(clr_n), .load_n(load_n), .enp(enp),
    .ent(ent), .up(up), .p(p), .q(q0), .tco(tco0), .rco_n(rco0));
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .CLR_SYNC(1)) u1 (
    .clk(clk), .reset_n(reset_n), .ce(ce_c), .clr_n(clr_n), .load_n(load_n), .enp(enp),
    .ent(tco0), .up(up), .p(p), .q(q1), .tco(tco1), .rco_n(rco1));
  ttl_counter_mod #(.WIDTH(4), .MODULUS(16), .CLR_SYNC(0)) ua (
    .clk(clk), .reset_n(reset_n), .ce(ce_a), .clr_n(clr_a), .load_n(load_n), .enp(enp),
    .ent(ent), .up(up), .p(p), .q(q_a), .tco(tco_a), .rco_n(rco_a));
  typedef struct {
    logic ce, clr_n, load_n, enp, ent, up;
    logic [3:0] p, q;
    logic tco;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic [5:0] c, input logic [3:0] pv, input logic [3:0] qv, input logic t);
    vec_t v;
    {v.ce, v.clr_n, v.load_n, v.enp, v.ent, v.up} = c;
    v.p = pv;
    v.q = qv;
    v.tco = t;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  initial begin
`ifdef TTL_COUNTER_RCO_EN
    rco_exp = 1'b0;
`else
    rco_exp = 1'b1;
`endif
    // ce clr_n load_n enp ent up
    tbl.push_back(mk(6'b110110, 4'd3, 4'd3, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd2, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd1, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd0, 1'b1));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd9, 1'b0));
    tbl.push_back(mk(6'b011110, 4'd0, 4'd9, 1'b0));
    tbl.push_back(mk(6'b111111, 4'd0, 4'd0, 1'b0));
    tbl.push_back(mk(6'b110111, 4'd5, 4'd5, 1'b0));
    tbl.push_back(mk(6'b100111, 4'd11, 4'd0, 1'b0));
    tbl.push_back(mk(6'b110111, 4'd11, 4'd11, 1'b0));
    tbl.push_back(mk(6'b111111, 4'd0, 4'd12, 1'b0));
    tbl.push_back(mk(6'b110111, 4'd14, 4'd14, 1'b0));
    tbl.push_back(mk(6'b111111, 4'd0, 4'd15, 1'b0));
    tbl.push_back(mk(6'b111111, 4'd0, 4'd0, 1'b0));
    tbl.push_back(mk(6'b111111, 4'd0, 4'd1, 1'b0));
    tbl.push_back(mk(6'b110110, 4'd14, 4'd14, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd13, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd12, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd11, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd10, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd9, 1'b0));
    tbl.push_back(mk(6'b111011, 4'd0, 4'd9, 1'b1));
    tbl.push_back(mk(6'b111001, 4'd0, 4'd9, 1'b0));
    tbl.push_back(mk(6'b110001, 4'd4, 4'd4, 1'b0));
    tbl.push_back(mk(6'b111110, 4'd0, 4'd3, 1'b0));
    // reset state: down mode with ent=1 gives tco=1 on the MODULUS=10 stage
    #2;
    chk("rst_q_d", 32'(q_d), 32'd0);
    chk("rst_q_cascade", 32'({q1, q0}), 32'd0);
    chk("rst_q_a", 32'(q_a), 32'd0);
    chk("rst_tco_down", 32'(tco_d), 32'd1);
    chk("rst_rco", 32'(rco_d), 32'd1);
    @(negedge clk);
    reset_n = 1;
    foreach (tbl[i]) begin
      {ce_d, clr_n, load_n, enp, ent, up} = {tbl[i].ce, tbl[i].clr_n, tbl[i].load_n, tbl[i].enp, tbl[i].ent, tbl[i].up};
      p = tbl[i].p;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_q", i), 32'(q_d), 32'(tbl[i].q));
      chk($sformatf("vec%0d_tco", i), 32'(tco_d), 32'(tbl[i].tco));
    end
    ce_d = 0;
    // binary cascade: 255 ce pulses to FF, one more wraps to 00
    {clr_n, load_n, enp, ent, up} = 5'b11111;
    ce_c = 1;
    repeat (255) @(posedge clk);
    @(negedge clk);
    ce_c = 0;
    chk("cascade_ff", 32'({q1, q0}), 32'hff);
    chk("cascade_tco1", 32'(tco1), 32'd1);
    ce_c = 1;
    @(posedge clk);
    @(negedge clk);
    ce_c = 0;
    chk("cascade_wrap", 32'({q1, q0}), 32'h00);
    chk("cascade_tco1_wrap", 32'(tco1), 32'd0);
    // async reset mid-count at q=7
    load_n = 0; p = 4'd6; ce_d = 1;
    @(negedge clk);
    load_n = 1;
    @(negedge clk);
    chk("count_to_7", 32'(q_d), 32'd7);
    #2 reset_n = 0;
    #1 chk("async_reset", 32'(q_d), 32'd0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    @(negedge clk);
    ce_d = 0;
    chk("resume_after_reset", 32'(q_d), 32'd1);
    // CLR_SYNC=0 instance: clr_n clears between clocks
    load_n = 0; p = 4'd9; ce_a = 1;
    @(negedge clk);
    load_n = 1;
    @(negedge clk);
    chk("a_count", 32'(q_a), 32'd10);
    ce_a = 0;
    #2 clr_a = 0;
    #1 chk("a_async_clr", 32'(q_a), 32'd0);
    @(negedge clk);
    clr_a = 1;
    // ce=0 for 10 clocks holds despite load and count requests
    load_n = 0; p = 4'd6; ce_a = 1;
    @(negedge clk);
    chk("a_load6", 32'(q_a), 32'd6);
    ce_a = 0; p = 4'd2; up = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("a_ce_hold", 32'(q_a), 32'd6);
    // rco_n strobe at q=15 counting up
    load_n = 0; p = 4'd15; up = 1; ce_a = 1;
    @(negedge clk);
    load_n = 1; ce_a = 0;
    #1 chk("a_tco15", 32'(tco_a), 32'd1);
    chk("a_rco_no_ce", 32'(rco_a), 32'd1);
    ce_a = 1;
    #1 chk("a_rco_ce", 32'(rco_a), 32'(rco_exp));
    @(posedge clk);
    @(negedge clk);
    ce_a = 0;
    chk("a_wrap0", 32'(q_a), 32'd0);
    chk("a_rco_after", 32'(rco_a), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
